// File: rtl/alu_seq.sv
// alu_seq: handshaked, parametrised ALU with an internal carry register.
// Single-cycle ops complete on the accept edge. SHLN, SHRN and MUL iterate
// one step per cycle in BUSY. Results, flags and carry are held in DONE
// until the consumer takes them.
module alu_seq #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned IMM_W   = WIDTH / 2,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         alu_cmd,
  input  logic [2:0]         typeselect,
  input  logic [WIDTH-1:0]   inA,
  input  logic [WIDTH-1:0]   inB,
  input  logic [IMM_W-1:0]   immed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   rslt,
  output logic               sc_o,
  output logic               notequal,
  output logic               lessthan
);

  // The counter must be able to hold WIDTH, which is the MUL step count.
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  localparam logic [2:0] OpRxor = 3'b000;
  localparam logic [2:0] OpShft = 3'b001;
  localparam logic [2:0] OpCmp  = 3'b010;
  localparam logic [2:0] OpHalf = 3'b011;
  localparam logic [2:0] OpAnd  = 3'b100;
  localparam logic [2:0] OpShln = 3'b101;
  localparam logic [2:0] OpShrn = 3'b110;
  localparam logic [2:0] OpMul  = 3'b111;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  // Working register: the low half is the shift accumulator; MUL uses all
  // of it as {partial product, remaining multiplier bits}.
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     rslt_q, rslt_d;
  logic                 c_q, c_d;
  logic                 ne_q, ne_d;
  logic                 lt_q, lt_d;

  logic                 accept;
  logic [SHAMT_W-1:0]   amt;
  logic                 iterative;
  logic [WIDTH-1:0]     imm_rslt;
  logic                 imm_c;
  logic                 imm_ne;
  logic                 imm_lt;
  logic [2*WIDTH-1:0]   step_prod;
  logic [WIDTH-1:0]     step_rslt;
  logic                 step_c;
  logic [WIDTH-1:0]     addend;
  logic [WIDTH:0]       mul_sum;

  // in_ready is masked by reset so that it reads 0 while reset is held.
  assign in_ready  = (state_q == StIdle) && reset_n;
  assign out_valid = (state_q == StDone);
  assign accept    = in_valid && in_ready;
  assign amt       = inB[SHAMT_W-1:0];
  assign rslt      = rslt_q;
  assign sc_o      = c_q;
  assign notequal  = ne_q;
  assign lessthan  = lt_q;

  // Single-cycle result, carry and flags, computed straight from the inputs.
  always_comb begin
    imm_rslt  = '0;
    imm_c     = c_q;
    imm_ne    = ne_q;
    imm_lt    = lt_q;
    iterative = 1'b0;
    case (alu_cmd)
      OpRxor: imm_rslt = WIDTH'(^inA);
      OpShft: begin
        case (typeselect)
          3'b000: begin imm_rslt = {inA[WIDTH-2:0], 1'b0}; imm_c = 1'b0;   end
          3'b001: begin imm_rslt = {inA[WIDTH-2:0], 1'b1}; imm_c = 1'b0;   end
          3'b010: begin imm_rslt = {1'b0, inA[WIDTH-1:1]}; imm_c = inA[0]; end
          3'b011: begin imm_rslt = {1'b1, inA[WIDTH-1:1]}; imm_c = inA[0]; end
          3'b100: begin
            imm_rslt = {inA[WIDTH-2:0], c_q};
            imm_c    = inA[WIDTH-1];
          end
          3'b101: begin
            imm_rslt = {c_q, inA[WIDTH-1:1]};
            imm_c    = inA[0];
          end
          3'b110:  imm_rslt = (inA == '0) ? '0 : inA - WIDTH'(1);
          default: imm_rslt = inA + WIDTH'(1);
        endcase
      end
      OpCmp: begin
        imm_ne = (inA != inB);
        imm_lt = ($signed(inA) < $signed(inB));
      end
      OpHalf: imm_rslt = WIDTH'({inA[IMM_W-1:0], immed});
      OpAnd:  imm_rslt = inA & inB;
      OpShln, OpShrn: begin
        // A zero shift amount completes at once with the operand untouched.
        imm_rslt  = inA;
        iterative = (amt != '0);
      end
      default: iterative = 1'b1;
    endcase
  end

  // One iteration step of the op latched in op_q.
  always_comb begin
    addend    = prod_q[0] ? mcand_q : '0;
    mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    step_prod = prod_q;
    step_rslt = prod_q[WIDTH-1:0];
    step_c    = c_q;
    case (op_q)
      OpShln: begin
        step_prod = {{WIDTH{1'b0}}, prod_q[WIDTH-2:0], 1'b0};
        step_rslt = step_prod[WIDTH-1:0];
        step_c    = prod_q[WIDTH-1];
      end
      OpShrn: begin
        step_prod = {{WIDTH{1'b0}}, 1'b0, prod_q[WIDTH-1:1]};
        step_rslt = step_prod[WIDTH-1:0];
        step_c    = prod_q[0];
      end
      default: begin
        step_prod = {mul_sum, prod_q[WIDTH-1:1]};
        step_rslt = step_prod[WIDTH-1:0];
        step_c    = |step_prod[2*WIDTH-1:WIDTH];
      end
    endcase
  end

  // FSM next state. Result and carry commit only on entry to DONE.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    rslt_d  = rslt_q;
    c_d     = c_q;
    ne_d    = ne_q;
    lt_d    = lt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (iterative) begin
            state_d = StBusy;
            op_d    = alu_cmd;
            mcand_d = inA;
            if (alu_cmd == OpMul) begin
              cnt_d  = CNT_W'(WIDTH);
              prod_d = {{WIDTH{1'b0}}, inB};
            end else begin
              cnt_d  = CNT_W'(amt);
              prod_d = {{WIDTH{1'b0}}, inA};
            end
          end else begin
            state_d = StDone;
            rslt_d  = imm_rslt;
            c_d     = imm_c;
            ne_d    = imm_ne;
            lt_d    = imm_lt;
          end
        end
      end
      StBusy: begin
        cnt_d  = cnt_q - CNT_W'(1);
        prod_d = step_prod;
        if (cnt_q == CNT_W'(1)) begin
          state_d = StDone;
          rslt_d  = step_rslt;
          c_d     = step_c;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any op in flight and clears carry and flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      op_q    <= '0;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      rslt_q  <= '0;
      c_q     <= 1'b0;
      ne_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      rslt_q  <= rslt_d;
      c_q     <= c_d;
      ne_q    <= ne_d;
      lt_q    <= lt_d;
    end
  end

endmodule
